// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the simple-CPU hardwired sequencers.
// Contents:
//   state_e        - sequencer state (IDLE, T0-T6, DONE, FAULT)
//   OP_*           - register-register ALU opcodes (IR[31:27])
//   FC_*           - fault_code values
//   is_alu_rr(op)  - 1 when op is a legal register-register ALU opcode
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_DONE,
        S_FAULT
    } state_e;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_SHR = 5'b00111;
    localparam logic [4:0] OP_SHL = 5'b01000;
    localparam logic [4:0] OP_ROR = 5'b01001;
    localparam logic [4:0] OP_ROL = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    function automatic logic is_alu_rr(input logic [4:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHL, OP_ROR, OP_ROL, OP_MUL, OP_DIV: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory wait-state counter for the fetch read phase.
// Ports:
//   Clock      in   clock, rising edge
//   clear      in   asynchronous active-high reset
//   i_clr      in   synchronous clear (priority over i_en)
//   i_en       in   count one wait cycle
//   o_zero     out  counter is 0 (first cycle of a read phase)
//   o_expired  out  counter has reached LIMIT (never when LIMIT=0)
module seq_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic Clock,
    input  logic clear,
    input  logic i_clr,
    input  logic i_en,
    output logic o_zero,
    output logic o_expired
);

    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] r_cnt;

    // Saturates at all-ones so a long wait can never wrap back to 0,
    // which would re-signal a "first" read cycle.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != {CW{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_zero    = (r_cnt == '0);
    assign o_expired = (LIMIT > 0) && (r_cnt == LIM);

endmodule

// File: rtl/alu_rr_sequencer.sv
// Hardwired control sequencer for one register-register ALU instruction.
// Fetch T0-T2 (with memory wait-states and timeout in T1), operands/ALU
// T3-T5, T6 for the HI half of MUL/DIV, then a DONE or FAULT pulse.
// Ports:
//   Clock, clear           clock / asynchronous active-high reset
//   start                  request an instruction (IDLE, or DONE if CONTINUOUS)
//   mem_ready              memory read data valid
//   ir_opcode              IR[31:27]
//   PCout..IRin            fetch strobes
//   GRA..LOin              execute strobes
//   alu_op                 ALU select, non-zero only in T4
//   busy, done, fault      status; fault_code valid with fault
module alu_rr_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter bit CONTINUOUS  = 1'b0
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [OPCODE_W-1:0] ir_opcode,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                GRA,
    output logic                GRB,
    output logic                GRC,
    output logic                Rout,
    output logic                Rin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                ZHighout,
    output logic                HIin,
    output logic                LOin,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [1:0]          fault_code
);

    state_e              r_state, w_state_nxt;
    logic [OPCODE_W-1:0] r_op;
    logic [1:0]          r_fcode, w_fcode_nxt;
    logic                w_hi_zero, w_legal, w_muldiv;
    logic                w_t1_first, w_expired;

    // Opcodes wider than the 5-bit field are legal only with zero upper bits.
    generate
        if (OPCODE_W > 5) begin : g_wide
            assign w_hi_zero = ~|ir_opcode[OPCODE_W-1:5];
        end else begin : g_narrow
            assign w_hi_zero = 1'b1;
        end
    endgenerate

    assign w_legal  = w_hi_zero && is_alu_rr(ir_opcode[4:0]);
    assign w_muldiv = (r_op == OPCODE_W'(OP_MUL)) || (r_op == OPCODE_W'(OP_DIV));

    seq_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait (
        .Clock     (Clock),
        .clear     (clear),
        .i_clr     ((r_state != S_T1) || mem_ready),
        .i_en      ((r_state == S_T1) && !mem_ready),
        .o_zero    (w_t1_first),
        .o_expired (w_expired)
    );

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_fcode <= FC_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_fcode <= w_fcode_nxt;
            if (r_state == S_T3)
                r_op <= ir_opcode;
        end
    end

    // r_fcode is only loaded on entry to FAULT, so it is 0 everywhere else.
    always_comb begin
        w_state_nxt = r_state;
        w_fcode_nxt = FC_NONE;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_T0;
            S_T0:    w_state_nxt = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    w_state_nxt = S_T2;
                end else if (w_expired) begin
                    w_state_nxt = S_FAULT;
                    w_fcode_nxt = FC_TIMEOUT;
                end
            end
            S_T2:    w_state_nxt = S_T3;
            S_T3: begin
                if (w_legal) begin
                    w_state_nxt = S_T4;
                end else begin
                    w_state_nxt = S_FAULT;
                    w_fcode_nxt = FC_ILLEGAL;
                end
            end
            S_T4:    w_state_nxt = S_T5;
            S_T5:    w_state_nxt = w_muldiv ? S_T6 : S_DONE;
            S_T6:    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = (CONTINUOUS && start) ? S_T0 : S_IDLE;
            S_FAULT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; PCin = 1'b0;
        Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        GRA = 1'b0; GRB = 1'b0; GRC = 1'b0; Rout = 1'b0; Rin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0;
        HIin = 1'b0; LOin = 1'b0;
        alu_op = '0;
        busy = (r_state != S_IDLE);
        done = 1'b0;
        fault = 1'b0;
        fault_code = r_fcode;
        case (r_state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin
                Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
                // PC reload only once; wait cycles must not re-latch it.
                PCin = w_t1_first;
            end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            S_T4: begin GRC = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = r_op; end
            S_T5: begin
                Zlowout = 1'b1;
                if (w_muldiv) LOin = 1'b1;
                else begin GRA = 1'b1; Rin = 1'b1; end
            end
            S_T6:    begin ZHighout = 1'b1; HIin = 1'b1; end
            S_DONE:  done = 1'b1;
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Randomized self-checking bench for alu_rr_sequencer (MEM_TIMEOUT=4,
// CONTINUOUS=1). Latency is reported in the "cycle n+L" sense: L is the
// number of edges after the start-sampling edge at which done/fault is
// first seen, plus one.
module tb_alu_rr_sequencer;
    localparam int TMO = 4;

    logic Clock, clear, start, mem_ready;
    logic [4:0] ir_opcode;
    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic GRA, GRB, GRC, Rout, Rin, Yin, Zin, Zlowout, ZHighout, HIin, LOin;
    logic [4:0] alu_op;
    logic busy, done, fault;
    logic [1:0] fault_code;
    logic [28:0] all_o;

    int errs = 0, nchk = 0;

    alu_rr_sequencer #(.OPCODE_W(5), .MEM_TIMEOUT(TMO), .CONTINUOUS(1'b1)) dut (
        .Clock(Clock), .clear(clear), .start(start), .mem_ready(mem_ready),
        .ir_opcode(ir_opcode),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rout(Rout), .Rin(Rin), .Yin(Yin),
        .Zin(Zin), .Zlowout(Zlowout), .ZHighout(ZHighout), .HIin(HIin), .LOin(LOin),
        .alu_op(alu_op), .busy(busy), .done(done), .fault(fault),
        .fault_code(fault_code)
    );

    assign all_o = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                    GRA, GRB, GRC, Rout, Rin, Yin, Zin, Zlowout, ZHighout,
                    HIin, LOin, alu_op, busy, done, fault, fault_code};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One instruction: w = memory wait cycles before data is ready.
    task automatic run(input logic [4:0] op, input int w);
        bit legal, md, tmo, fin;
        int k, rd, pcin, rin, lo, hi, zin, aop_n, aop_bad, code, e_lat;
        logic [4:0] aop_v;
        legal = (op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd15, 5'd16});
        md    = (op == 5'd15) || (op == 5'd16);
        tmo   = (w > TMO);
        e_lat = tmo ? TMO + 3 : (!legal ? 5 + w : (md ? 8 + w : 7 + w));
        ir_opcode = op;
        mem_ready = 1'b0;
        {k, rd, pcin, rin, lo, hi, zin, aop_n, aop_bad, code} = '0;
        aop_v = '0;
        fin = 1'b0;
        start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        while (!fin && k < 40) begin
            if (Read) rd++;
            mem_ready = (rd > w);
            pcin += int'(PCin);
            rin  += int'(Rin);
            lo   += int'(LOin);
            hi   += int'(HIin);
            zin  += int'(Zin);
            if (alu_op != 0) begin
                aop_n++;
                aop_v = alu_op;
                if (!(GRC && Zin)) aop_bad++;
            end
            if (done || fault) begin
                fin = 1'b1;
                code = fault ? int'(fault_code) : 0;
                chk("fault", int'(fault), int'(tmo || !legal));
            end else begin
                @(posedge Clock); #1;
                k++;
            end
        end
        chk("lat", k + 1, e_lat);
        chk("code", code, tmo ? 2 : (!legal ? 1 : 0));
        chk("read_cyc", rd, tmo ? TMO + 1 : w + 1);
        chk("pcin_cyc", pcin, 1);
        chk("rin_cyc", rin, (!tmo && legal && !md) ? 1 : 0);
        chk("lo_cyc", lo, (!tmo && legal && md) ? 1 : 0);
        chk("hi_cyc", hi, (!tmo && legal && md) ? 1 : 0);
        chk("zin_cyc", zin, 1 + int'(!tmo && legal));
        chk("aluop_cyc", aop_n, int'(!tmo && legal));
        chk("aluop_t4", aop_bad, 0);
        if (aop_n != 0) chk("aluop_val", int'(aop_v), int'(op));
        @(posedge Clock); #1;
        chk("idle_after", int'(all_o), 0);
    endtask

    initial begin
        logic [31:0] ir;
        int k;
        clear = 1'b1; start = 1'b0; mem_ready = 1'b0; ir_opcode = '0;
        #12;
        chk("reset_out", int'(all_o), 0);
        @(negedge Clock); clear = 1'b0;
        @(posedge Clock); #1;
        chk("idle_out", int'(all_o), 0);

        ir = 32'h2A1B8000;         // AND R4,R3,R7
        run(ir[31:27], 0);
        run(5'b01111, 0);          // MUL
        run(5'b00011, 3);          // three wait-states
        run(5'b00100, 99);         // memory never ready
        run(5'b11111, 0);          // illegal

        // clear during T4
        ir_opcode = 5'b00110; mem_ready = 1'b1; start = 1'b1;
        @(posedge Clock); #1; start = 1'b0;
        k = 0;
        while (!(GRC && Zin) && k < 20) begin @(posedge Clock); #1; k++; end
        chk("reach_t4", k, 4);
        #2 clear = 1'b1;
        #1;
        chk("clr_out", int'(all_o), 0);
        chk("clr_busy", int'(busy), 0);
        @(negedge Clock); clear = 1'b0;
        run(5'b00110, 0);          // full fetch after clear

        // back-to-back issue with start held
        ir_opcode = 5'b00011; mem_ready = 1'b1; start = 1'b1;
        @(posedge Clock); #1;
        k = 0;
        while (!done && k < 20) begin @(posedge Clock); #1; k++; end
        chk("cont_lat1", k + 1, 7);
        @(posedge Clock); #1;
        chk("cont_t0", int'(PCout && MARin && busy), 1);
        start = 1'b0;
        k = 1;
        while (!done && k < 20) begin @(posedge Clock); #1; k++; end
        chk("cont_lat2", k, 7);
        @(posedge Clock); #1;
        chk("cont_idle", int'(busy), 0);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            logic [4:0] lt [10] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd15, 5'd16};
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : lt[$urandom_range(0, 9)];
            run(op, int'($urandom_range(0, 6)));
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
